// File: rtl/scv_timing_pkg.sv
// Shared timing definitions for the SCV clock / VBL generator: phase kinds,
// NTSC default VBL durations and the duration clamp helper.
package scv_timing_pkg;

    typedef enum logic [2:0] {
        PH_CP1P,
        PH_CP1N,
        PH_CP2P,
        PH_CP2N,
        PH_NONE
    } cp_phase_e;

    // NTSC VBL durations in master clocks (8 clocks per dot-group)
    localparam int unsigned VBL_LO_NTSC = 32'd120872;
    localparam int unsigned VBL_HI_NTSC = 32'd12464;

    localparam int unsigned DUR_W = 32;

    // A zero duration would stall the VBL counter forever; treat it as one clock.
    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/scv_cp_phase_seq.sv
// uPD7801 CP1/CP2 phase sequencer: divides the master clock into CP_DIV
// phases and emits registered edge strobes and phase levels, freezable by stall.
module scv_cp_phase_seq
    import scv_timing_pkg::*;
#(
    parameter int unsigned CP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic cp1_posedge,
    output logic cp1_negedge,
    output logic cp2_posedge,
    output logic cp2_negedge,
    output logic cp1,
    output logic cp2
);

    localparam int unsigned Q  = CP_DIV / 4;
    localparam int unsigned PW = (CP_DIV > 2) ? $clog2(CP_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CP_DIV - 1);
    localparam logic [PW-1:0] PH_Q    = PW'(Q);
    localparam logic [PW-1:0] PH_2Q   = PW'(2 * Q);
    localparam logic [PW-1:0] PH_3Q   = PW'(3 * Q);

    // ph holds the phase to be emitted on the next unstalled edge
    logic [PW-1:0] ph;
    logic [PW-1:0] ph_nxt;
    cp_phase_e     kind;
    logic          cp1p_nxt;
    logic          cp1n_nxt;
    logic          cp2p_nxt;
    logic          cp2n_nxt;
    logic          cp1_nxt;
    logic          cp2_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph          <= '0;
            cp1_posedge <= 1'b0;
            cp1_negedge <= 1'b0;
            cp2_posedge <= 1'b0;
            cp2_negedge <= 1'b0;
            cp1         <= 1'b0;
            cp2         <= 1'b0;
        end else begin
            ph          <= ph_nxt;
            cp1_posedge <= cp1p_nxt;
            cp1_negedge <= cp1n_nxt;
            cp2_posedge <= cp2p_nxt;
            cp2_negedge <= cp2n_nxt;
            cp1         <= cp1_nxt;
            cp2         <= cp2_nxt;
        end
    end

    // Phase decode for the value about to be emitted
    always_comb begin
        kind = PH_NONE;
        if (ph == '0) begin
            kind = PH_CP1P;
        end else if (ph == PH_Q) begin
            kind = PH_CP1N;
        end else if (ph == PH_2Q) begin
            kind = PH_CP2P;
        end else if (ph == PH_3Q) begin
            kind = PH_CP2N;
        end
    end

    always_comb begin
        ph_nxt   = ph;
        cp1p_nxt = 1'b0;
        cp1n_nxt = 1'b0;
        cp2p_nxt = 1'b0;
        cp2n_nxt = 1'b0;
        cp1_nxt  = cp1;
        cp2_nxt  = cp2;
        if (!stall) begin
            ph_nxt   = (ph == PH_LAST) ? '0 : ph + PW'(1);
            cp1p_nxt = (kind == PH_CP1P);
            cp1n_nxt = (kind == PH_CP1N);
            cp2p_nxt = (kind == PH_CP2P);
            cp2n_nxt = (kind == PH_CP2N);
            cp1_nxt  = (ph < PH_2Q);
            cp2_nxt  = !(ph < PH_2Q);
        end
    end

endmodule

// File: rtl/scv_clk_vbl_gen.sv
// SCV timing generator top: CPU phase strobes plus the VBL (INT2) level with
// run-time reloadable durations, rise strobe and frame counter.
module scv_clk_vbl_gen
    import scv_timing_pkg::*;
#(
    parameter int unsigned CP_DIV     = 4,
    parameter int unsigned TW         = 20,
    parameter int unsigned VBL_LO_DEF = VBL_LO_NTSC,
    parameter int unsigned VBL_HI_DEF = VBL_HI_NTSC,
    parameter int unsigned FW         = 16
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          STALL,
    input  logic [TW-1:0] CFG_LO,
    input  logic [TW-1:0] CFG_HI,
    input  logic          CFG_LOAD,
    output logic          CP1_POSEDGE,
    output logic          CP1_NEGEDGE,
    output logic          CP2_POSEDGE,
    output logic          CP2_NEGEDGE,
    output logic          CP1,
    output logic          CP2,
    output logic          VBL,
    output logic          VBL_RISE,
    output logic [FW-1:0] FRAME
);

    localparam logic [TW-1:0] LO_RST = TW'(VBL_LO_DEF);
    localparam logic [TW-1:0] HI_RST = TW'(VBL_HI_DEF);

    scv_cp_phase_seq #(
        .CP_DIV (CP_DIV)
    ) u_phase_seq (
        .clk         (CLK),
        .rst         (RES),
        .stall       (STALL),
        .cp1_posedge (CP1_POSEDGE),
        .cp1_negedge (CP1_NEGEDGE),
        .cp2_posedge (CP2_POSEDGE),
        .cp2_negedge (CP2_NEGEDGE),
        .cp1         (CP1),
        .cp2         (CP2)
    );

    logic [TW-1:0] vc;
    logic [TW-1:0] lo_act;
    logic [TW-1:0] hi_act;
    logic [TW-1:0] lo_shd;
    logic [TW-1:0] hi_shd;
    logic          pend;

    logic [TW-1:0] vc_nxt;
    logic [TW-1:0] lo_act_nxt;
    logic [TW-1:0] hi_act_nxt;
    logic [TW-1:0] lo_shd_nxt;
    logic [TW-1:0] hi_shd_nxt;
    logic          pend_nxt;
    logic          vbl_nxt;
    logic          vbl_rise_nxt;
    logic [FW-1:0] frame_nxt;
    logic [TW-1:0] dur_eff;
    logic          xfer;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            vc       <= '0;
            lo_act   <= LO_RST;
            hi_act   <= HI_RST;
            lo_shd   <= '0;
            hi_shd   <= '0;
            pend     <= 1'b0;
            VBL      <= 1'b0;
            VBL_RISE <= 1'b0;
            FRAME    <= '0;
        end else begin
            vc       <= vc_nxt;
            lo_act   <= lo_act_nxt;
            hi_act   <= hi_act_nxt;
            lo_shd   <= lo_shd_nxt;
            hi_shd   <= hi_shd_nxt;
            pend     <= pend_nxt;
            VBL      <= vbl_nxt;
            VBL_RISE <= vbl_rise_nxt;
            FRAME    <= frame_nxt;
        end
    end

    // vc counts edges spent in the current level; the level flips once it reaches the duration
    always_comb begin
        dur_eff = TW'(clamp_dur(DUR_W'(VBL ? hi_act : lo_act)));
        xfer    = (vc >= dur_eff);
    end

    always_comb begin
        vc_nxt       = vc + TW'(1);
        lo_act_nxt   = lo_act;
        hi_act_nxt   = hi_act;
        lo_shd_nxt   = lo_shd;
        hi_shd_nxt   = hi_shd;
        pend_nxt     = pend;
        vbl_nxt      = VBL;
        vbl_rise_nxt = 1'b0;
        frame_nxt    = FRAME;

        if (xfer) begin
            vc_nxt       = TW'(1);
            vbl_nxt      = !VBL;
            vbl_rise_nxt = !VBL;
            if (!VBL) begin
                frame_nxt = FRAME + FW'(1);
            end
            // Only a config captured before this edge takes effect here
            if (pend) begin
                lo_act_nxt = lo_shd;
                hi_act_nxt = hi_shd;
                pend_nxt   = 1'b0;
            end
        end

        // A load on a transition edge stays pending for the following transition
        if (CFG_LOAD) begin
            lo_shd_nxt = CFG_LO;
            hi_shd_nxt = CFG_HI;
            pend_nxt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_scv_clk_vbl_gen.sv
// Directed self-checking bench for scv_clk_vbl_gen: phase strobes at CP_DIV 4/8,
// stall behaviour, VBL timing, config reload, zero durations, wrap and async reset.
module tb_scv_clk_vbl_gen;

    localparam int unsigned TW = 20;
    localparam int unsigned FW = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          stall;
    logic [TW-1:0] cfg_lo;
    logic [TW-1:0] cfg_hi;
    logic          cfg_load;

    logic          a_cp1p, a_cp1n, a_cp2p, a_cp2n, a_cp1, a_cp2, a_vbl, a_rise;
    logic [FW-1:0] a_frame;
    logic          b_cp1p, b_cp1n, b_cp2p, b_cp2n, b_cp1, b_cp2, b_vbl, b_rise;
    logic [FW-1:0] b_frame;

    logic [3:0]    a_strb;
    logic [3:0]    b_strb;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign a_strb = {a_cp1p, a_cp1n, a_cp2p, a_cp2n};
    assign b_strb = {b_cp1p, b_cp1n, b_cp2p, b_cp2n};

    scv_clk_vbl_gen #(
        .CP_DIV(4), .TW(TW), .VBL_LO_DEF(10), .VBL_HI_DEF(3), .FW(FW)
    ) u_dut4 (
        .CLK(clk), .RES(res), .STALL(stall),
        .CFG_LO(cfg_lo), .CFG_HI(cfg_hi), .CFG_LOAD(cfg_load),
        .CP1_POSEDGE(a_cp1p), .CP1_NEGEDGE(a_cp1n),
        .CP2_POSEDGE(a_cp2p), .CP2_NEGEDGE(a_cp2n),
        .CP1(a_cp1), .CP2(a_cp2),
        .VBL(a_vbl), .VBL_RISE(a_rise), .FRAME(a_frame)
    );

    scv_clk_vbl_gen #(
        .CP_DIV(8), .TW(TW), .VBL_LO_DEF(10), .VBL_HI_DEF(3), .FW(FW)
    ) u_dut8 (
        .CLK(clk), .RES(res), .STALL(stall),
        .CFG_LO(cfg_lo), .CFG_HI(cfg_hi), .CFG_LOAD(cfg_load),
        .CP1_POSEDGE(b_cp1p), .CP1_NEGEDGE(b_cp1n),
        .CP2_POSEDGE(b_cp2p), .CP2_NEGEDGE(b_cp2n),
        .CP1(b_cp1), .CP2(b_cp2),
        .VBL(b_vbl), .VBL_RISE(b_rise), .FRAME(b_frame)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
    endtask

    initial begin
        logic [3:0] e4;
        logic [3:0] e8;
        int         ph4;
        int         ph8;
        bit         found;

        res      = 1'b1;
        stall    = 1'b0;
        cfg_lo   = '0;
        cfg_hi   = '0;
        cfg_load = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst strb4", 32'(a_strb), 32'h0);
        check("rst strb8", 32'(b_strb), 32'h0);
        check("rst cp1/cp2", 32'({a_cp1, a_cp2, b_cp1, b_cp2}), 32'h0);
        check("rst vbl", 32'({a_vbl, a_rise}), 32'h0);
        check("rst frame", 32'(a_frame), 32'h0);

        // Free-running phases and default VBL timing (LO=10, HI=3)
        res = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            ph4 = (k - 1) % 4;
            ph8 = (k - 1) % 8;
            e4  = 4'b1000 >> ph4;
            e8  = (ph8 % 2 == 0) ? (4'b1000 >> (ph8 / 2)) : 4'b0000;
            check($sformatf("t1 strb4 k=%0d", k), 32'(a_strb), 32'(e4));
            check($sformatf("t1 cp1_4 k=%0d", k), 32'({a_cp1, a_cp2}), (ph4 < 2) ? 32'h2 : 32'h1);
            check($sformatf("t1 strb8 k=%0d", k), 32'(b_strb), 32'(e8));
            check($sformatf("t1 cp1_8 k=%0d", k), 32'({b_cp1, b_cp2}), (ph8 < 4) ? 32'h2 : 32'h1);
            check($sformatf("t1 vbl k=%0d", k), 32'(a_vbl),
                  32'(((k >= 11) && (k <= 13)) || (k >= 24)));
            check($sformatf("t1 rise k=%0d", k), 32'(a_rise), 32'((k == 11) || (k == 24)));
            check($sformatf("t1 frame k=%0d", k), 32'(a_frame),
                  (k < 11) ? 32'd0 : ((k < 24) ? 32'd1 : 32'd2));
        end

        // Stall for 3 edges right after CP1_NEGEDGE at CP_DIV=8
        do_reset();
        tick();
        tick();
        tick();
        check("t2 cp1n8 edge3", 32'(b_strb), 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t2 stall strb8 i=%0d", i), 32'(b_strb), 32'h0);
            check($sformatf("t2 stall cp1_8 i=%0d", i), 32'({b_cp1, b_cp2}), 32'h2);
        end
        stall = 1'b0;
        tick();
        check("t2 edge7 strb8", 32'(b_strb), 32'h0);
        check("t2 edge7 cp1_8", 32'({b_cp1, b_cp2}), 32'h2);
        check("t2 edge7 strb4", 32'(a_strb), 32'h1);
        tick();
        check("t2 edge8 cp2p8", 32'(b_strb), 32'h2);
        check("t2 edge8 cp2_8", 32'({b_cp1, b_cp2}), 32'h1);
        check("t2 edge8 strb4", 32'(a_strb), 32'h8);
        tick();
        tick();
        tick();
        check("t2 vbl ignores stall", 32'({a_vbl, a_rise}), 32'h3);
        check("t2 frame", 32'(a_frame), 32'd1);

        // Config reload at edge 4 (5/2) and on the fall edge 13 (3/1)
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            cfg_load = (k == 4) || (k == 13) || (k == 27);
            cfg_lo   = (k == 4) ? TW'(5) : ((k == 13) ? TW'(3) : TW'(0));
            cfg_hi   = (k == 4) ? TW'(2) : ((k == 13) ? TW'(1) : TW'(0));
            tick();
            if (k <= 26) begin
                check($sformatf("t3 vbl k=%0d", k), 32'(a_vbl),
                      32'((k == 11) || (k == 12) || (k == 18) || (k == 22) || (k == 26)));
                check($sformatf("t3 rise k=%0d", k), 32'(a_rise),
                      32'((k == 11) || (k == 18) || (k == 22) || (k == 26)));
            end else begin
                // zero durations loaded on the fall edge 27, applied at the rise on 30
                check($sformatf("t4 vbl k=%0d", k), 32'(a_vbl), 32'((k >= 30) && (k % 2 == 0)));
                check($sformatf("t4 rise k=%0d", k), 32'(a_rise), 32'((k >= 30) && (k % 2 == 0)));
            end
        end
        cfg_load = 1'b0;
        check("t4 frame", 32'(a_frame), 32'd7);

        // Frame wrap
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            tick();
            if (a_rise && (a_frame == 8'hFF)) found = 1'b1;
        end
        check("t4 wrap reached", 32'(found), 32'h1);
        tick();
        check("t4 wrap fall", 32'({a_vbl, a_rise}), 32'h0);
        check("t4 wrap hold", 32'(a_frame), 32'hFF);
        tick();
        check("t4 wrap rise", 32'({a_vbl, a_rise}), 32'h3);
        check("t4 wrap zero", 32'(a_frame), 32'h0);

        // Async reset mid-high phase with a pending config
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cfg_load = (k == 12);
            cfg_lo   = TW'(7);
            cfg_hi   = TW'(7);
            tick();
        end
        cfg_load = 1'b0;
        check("t5 pre vbl", 32'(a_vbl), 32'h1);
        check("t5 pre strb4", 32'(a_strb), 32'h1);
        res = 1'b1;
        #1;
        check("t5 async vbl", 32'({a_vbl, a_rise}), 32'h0);
        check("t5 async frame", 32'(a_frame), 32'h0);
        check("t5 async strb", 32'({a_strb, b_strb}), 32'h0);
        check("t5 async lvl", 32'({a_cp1, a_cp2, b_cp1, b_cp2}), 32'h0);
        tick();
        tick();
        res = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("t5 vbl k=%0d", k), 32'(a_vbl), 32'((k >= 11) && (k <= 13)));
            check($sformatf("t5 rise k=%0d", k), 32'(a_rise), 32'(k == 11));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
